// File: rtl/dma_pkg.sv
// Shared state encoding and width defaults for the ADMA FIFO sequencer.
package dma_pkg;

  localparam int DATA_W         = 32;
  localparam int CNT_W          = 16;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    GAP,
    CMPL
  } state_t;

endpackage

// File: rtl/dma_xfer_counter.sv
// Word and block down-counters for one transfer; flags are combinational from registered counts.
// Words auto-reload on the last word of a block, so consecutive blocks need no idle cycle.
module dma_xfer_counter #(
  parameter int CNT_W = dma_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W:0]   load_words,
  input  logic [CNT_W-1:0] load_blocks,
  input  logic             reload,
  input  logic             dec,
  output logic             last_word,
  output logic             last_block
);

  logic [CNT_W:0]   wpb_q;
  logic [CNT_W:0]   word_q;
  logic [CNT_W-1:0] blk_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wpb_q  <= '0;
      word_q <= '0;
      blk_q  <= '0;
    end else if (load) begin
      wpb_q  <= load_words;
      word_q <= load_words;
      blk_q  <= (load_blocks == '0) ? CNT_W'(1) : load_blocks;
    end else if (dec) begin
      if (last_word) begin
        word_q <= wpb_q;
        blk_q  <= blk_q - CNT_W'(1);
      end else begin
        word_q <= word_q - (CNT_W+1)'(1);
      end
    end else if (reload) begin
      word_q <= wpb_q;
    end
  end

  assign last_word  = (word_q == (CNT_W+1)'(1));
  assign last_block = (blk_q == CNT_W'(1));

endmodule

// File: rtl/dma_fifo_sequencer.sv
// Moves words between the ADMA system port and the card FIFOs, block by block, 1 word/cycle.
// Data is a zero-latency pass-through; handshakes stall on FIFO empty/full or system backpressure.
module dma_fifo_sequencer #(
  parameter int DATA_W = dma_pkg::DATA_W,
  parameter int CNT_W  = dma_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              read_dir,
  input  logic [CNT_W-1:0]  block_size,
  input  logic [CNT_W-1:0]  block_count,
  input  logic              gap_stop,
  input  logic              continue_req,
  input  logic [DATA_W-1:0] rd_fifo_data,
  input  logic              rd_fifo_empty,
  output logic              rd_fifo_en,
  output logic [DATA_W-1:0] wr_fifo_data,
  input  logic              wr_fifo_full,
  output logic              wr_fifo_en,
  output logic [DATA_W-1:0] sys_wdata,
  output logic              sys_wvalid,
  input  logic              sys_wready,
  input  logic [DATA_W-1:0] sys_rdata,
  input  logic              sys_rvalid,
  output logic              sys_rready,
  output logic              busy,
  output logic              stopped_at_gap,
  output logic              block_done,
  output logic              transfer_complete
);

  import dma_pkg::*;

  state_t         state_q;
  state_t         state_d;
  logic           dir_q;
  logic           busy_q;
  logic           block_done_q;
  logic           tc_q;
  logic           gap_q;
  logic [CNT_W:0] wpb;
  logic           in_xfer;
  logic           hs;
  logic           blk_end;
  logic           tc_d;
  logic           load;
  logic           reload;
  logic           last_word;
  logic           last_block;

  // Round bytes up to whole words one bit wider so 0xFFFF cannot wrap.
  assign wpb = ({1'b0, block_size} + (CNT_W+1)'(BYTES_PER_WORD - 1)) >> $clog2(BYTES_PER_WORD);

  assign in_xfer    = (state_q == XFER) && !abort;
  assign sys_wvalid = in_xfer && dir_q && !rd_fifo_empty;
  assign rd_fifo_en = sys_wvalid && sys_wready;
  assign sys_rready = in_xfer && !dir_q && !wr_fifo_full;
  assign wr_fifo_en = sys_rready && sys_rvalid;
  assign sys_wdata    = rd_fifo_data;
  assign wr_fifo_data = sys_rdata;

  assign hs      = rd_fifo_en || wr_fifo_en;
  assign blk_end = hs && last_word;
  assign load    = (state_q == IDLE) && start && !abort;
  assign reload  = (state_q == GAP) && continue_req && !abort;
  // An empty transfer reaches CMPL without a final handshake, so CMPL raises the pulse itself.
  assign tc_d    = (blk_end && last_block) || ((state_q == CMPL) && !tc_q && !abort);

  dma_xfer_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .load_words  (wpb),
    .load_blocks (block_count),
    .reload      (reload),
    .dec         (hs),
    .last_word   (last_word),
    .last_block  (last_block)
  );

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = (wpb == '0) ? CMPL : XFER;
        XFER:    if (blk_end) state_d = last_block ? CMPL : (gap_stop ? GAP : XFER);
        GAP:     if (continue_req) state_d = XFER;
        CMPL:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      dir_q        <= 1'b0;
      busy_q       <= 1'b0;
      block_done_q <= 1'b0;
      tc_q         <= 1'b0;
      gap_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      block_done_q <= blk_end;
      tc_q         <= tc_d;
      gap_q        <= (state_d == GAP);
      if (load) dir_q <= read_dir;
      if (abort)     busy_q <= 1'b0;
      else if (load) busy_q <= 1'b1;
      else if (tc_d) busy_q <= 1'b0;
    end
  end

  assign busy              = busy_q;
  assign stopped_at_gap    = gap_q;
  assign block_done        = block_done_q;
  assign transfer_complete = tc_q;

endmodule

// File: tb/tb_dma_fifo_sequencer.sv
// Bench for dma_fifo_sequencer: per-cycle outputs versus a handshake-counting transfer model.
module tb_dma_fifo_sequencer;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, read_dir = 1'b0;
  logic [CW-1:0] block_size = '0, block_count = '0;
  logic          gap_stop = 1'b0, continue_req = 1'b0;
  logic [DW-1:0] rd_fifo_data = '0, sys_rdata = '0;
  logic          rd_fifo_empty = 1'b1, wr_fifo_full = 1'b0, sys_wready = 1'b0, sys_rvalid = 1'b0;
  logic          rd_fifo_en, wr_fifo_en, sys_wvalid, sys_rready;
  logic          busy, stopped_at_gap, block_done, transfer_complete;
  logic [DW-1:0] wr_fifo_data, sys_wdata;

  int    n_checks = 0;
  int    n_errors = 0;
  string tname = "";
  int    cnt_pop, cnt_push, cnt_bd, cnt_tc;

  // Model: a transfer is wpb*blocks handshakes; block ends every wpb handshakes.
  bit m_run, m_gap, m_empty, m_cmpl, m_busy, m_bd, m_tc, m_dir;
  int m_wpb, m_total, m_hs;

  dma_fifo_sequencer dut (
    .clk (clk), .reset_n (reset_n), .start (start), .abort (abort), .read_dir (read_dir),
    .block_size (block_size), .block_count (block_count), .gap_stop (gap_stop),
    .continue_req (continue_req), .rd_fifo_data (rd_fifo_data), .rd_fifo_empty (rd_fifo_empty),
    .rd_fifo_en (rd_fifo_en), .wr_fifo_data (wr_fifo_data), .wr_fifo_full (wr_fifo_full),
    .wr_fifo_en (wr_fifo_en), .sys_wdata (sys_wdata), .sys_wvalid (sys_wvalid),
    .sys_wready (sys_wready), .sys_rdata (sys_rdata), .sys_rvalid (sys_rvalid),
    .sys_rready (sys_rready), .busy (busy), .stopped_at_gap (stopped_at_gap),
    .block_done (block_done), .transfer_complete (transfer_complete)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] dut_vec();
    return {rd_fifo_en, wr_fifo_en, sys_wvalid, sys_rready,
            block_done, transfer_complete, busy, stopped_at_gap};
  endfunction

  function automatic logic [7:0] model_vec();
    logic ok, wv, rr;
    ok = m_run && !m_gap && !abort;
    wv = ok && m_dir && !rd_fifo_empty;
    rr = ok && !m_dir && !wr_fifo_full;
    return {wv && sys_wready, rr && sys_rvalid, wv, rr, m_bd, m_tc, m_busy, m_gap};
  endfunction

  task automatic model_reset();
    m_run = 0; m_gap = 0; m_empty = 0; m_cmpl = 0; m_busy = 0; m_bd = 0; m_tc = 0; m_dir = 0;
    m_wpb = 0; m_total = 0; m_hs = 0;
  endtask

  function automatic bit model_idle();
    return !m_run && !m_gap && !m_empty && !m_cmpl;
  endfunction

  // Applies the effect of the coming clock edge to the model, using the inputs now driven.
  task automatic model_advance();
    logic [7:0] e;
    bit idle, hs;
    e = model_vec();
    hs = e[7] | e[6];
    m_bd = 0;
    m_tc = 0;
    if (abort) begin
      m_run = 0; m_gap = 0; m_empty = 0; m_cmpl = 0; m_busy = 0;
      return;
    end
    idle = model_idle();
    m_cmpl = 0;
    if (start && idle) begin
      m_dir   = read_dir;
      m_wpb   = (int'(block_size) + 3) / 4;
      m_total = m_wpb * ((block_count == 0) ? 1 : int'(block_count));
      m_hs    = 0;
      m_busy  = 1;
      if (m_wpb == 0) m_empty = 1;
      else m_run = 1;
    end else if (m_empty) begin
      m_empty = 0; m_tc = 1; m_busy = 0;
    end else if (hs) begin
      m_hs++;
      if (m_hs % m_wpb == 0) begin
        m_bd = 1;
        if (m_hs == m_total) begin
          m_run = 0; m_busy = 0; m_tc = 1; m_cmpl = 1;
        end else if (gap_stop) begin
          m_gap = 1;
        end
      end
    end else if (m_gap && continue_req) begin
      m_gap = 0;
    end
  endtask

  task automatic tally();
    cnt_pop  += int'(rd_fifo_en);
    cnt_push += int'(wr_fifo_en);
    cnt_bd   += int'(block_done);
    cnt_tc   += int'(transfer_complete);
  endtask

  task automatic clear_tally();
    cnt_pop = 0; cnt_push = 0; cnt_bd = 0; cnt_tc = 0;
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; continue_req = 0; gap_stop = 0;
    rd_fifo_empty = 1; sys_wready = 0; sys_rvalid = 0; wr_fifo_full = 0;
  endtask

  task automatic test_reset();
    tname = "reset";
    model_reset();
    reset_n = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rd_fifo_data = $urandom; sys_rdata = $urandom; start = (c == 1);
      #1;
      n_checks++;
      if (dut_vec() !== 8'h00) begin
        n_errors++; $display("FAIL %s outputs cyc=%0d: got %b want 00000000", tname, c, dut_vec());
      end
      n_checks++;
      if (sys_wdata !== rd_fifo_data || wr_fifo_data !== sys_rdata) begin
        n_errors++; $display("FAIL %s passthrough: got %h/%h want %h/%h", tname, sys_wdata, wr_fifo_data, rd_fifo_data, sys_rdata);
      end
    end
    @(negedge clk);
    start = 0;
    reset_n = 1;
  endtask

  task automatic test_read_block();
    logic [DW-1:0] q[$];
    int first = -1, last = -1;
    tname = "read_16x2";
    for (int i = 0; i < 8; i++) q.push_back($urandom);
    clear_tally();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 0) begin
        idle_inputs(); read_dir = 1; block_size = 16; block_count = 2; sys_wready = 1;
      end
      start = (c == 0);
      rd_fifo_empty = (q.size() == 0);
      rd_fifo_data = (q.size() > 0) ? q[0] : '0;
      #1;
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_errors++; $display("FAIL %s cyc=%0d: outputs %b want %b", tname, c, dut_vec(), model_vec());
      end
      if (sys_wvalid && q.size() > 0) begin
        n_checks++;
        if (sys_wdata !== q[0]) begin
          n_errors++; $display("FAIL %s data: got %h want %h", tname, sys_wdata, q[0]);
        end
      end
      if (rd_fifo_en && q.size() > 0) begin
        if (first < 0) first = c;
        last = c;
        void'(q.pop_front());
      end
      tally();
      model_advance();
    end
    n_checks++;
    if (cnt_pop !== 8 || cnt_bd !== 2 || cnt_tc !== 1 || busy !== 1'b0) begin
      n_errors++; $display("FAIL %s totals: pops=%0d bd=%0d tc=%0d busy=%b want 8 2 1 0", tname, cnt_pop, cnt_bd, cnt_tc, busy);
    end
    n_checks++;
    if (last - first !== 7) begin
      n_errors++; $display("FAIL %s rate: span=%0d want 7", tname, last - first);
    end
  endtask

  task automatic test_write_full();
    int full_n = 0;
    tname = "write_6x1";
    clear_tally();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) begin
        idle_inputs(); read_dir = 0; block_size = 6; block_count = 1; sys_rvalid = 1;
      end
      start = (c == 0);
      sys_rdata = $urandom;
      wr_fifo_full = (cnt_push == 1 && full_n < 3);
      if (wr_fifo_full) full_n++;
      #1;
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_errors++; $display("FAIL %s cyc=%0d: outputs %b want %b", tname, c, dut_vec(), model_vec());
      end
      if (wr_fifo_full) begin
        n_checks++;
        if (sys_rready !== 1'b0) begin
          n_errors++; $display("FAIL %s rready_full: got %b want 0", tname, sys_rready);
        end
      end
      if (wr_fifo_en) begin
        n_checks++;
        if (wr_fifo_data !== sys_rdata) begin
          n_errors++; $display("FAIL %s data: got %h want %h", tname, wr_fifo_data, sys_rdata);
        end
      end
      tally();
      model_advance();
    end
    wr_fifo_full = 0;
    n_checks++;
    if (cnt_push !== 2 || cnt_bd !== 1 || cnt_tc !== 1) begin
      n_errors++; $display("FAIL %s totals: pushes=%0d bd=%0d tc=%0d want 2 1 1", tname, cnt_push, cnt_bd, cnt_tc);
    end
  endtask

  task automatic test_gap();
    int gap_len = 0, gaps = 0;
    logic prev_gap = 0;
    tname = "gap_8x3";
    clear_tally();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) begin
        idle_inputs(); read_dir = 1; block_size = 8; block_count = 3;
        gap_stop = 1; sys_wready = 1; rd_fifo_empty = 0;
      end
      start = (c == 0);
      rd_fifo_data = $urandom;
      continue_req = m_gap && (gap_len >= 2);
      gap_len = m_gap ? gap_len + 1 : 0;
      #1;
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_errors++; $display("FAIL %s cyc=%0d: outputs %b want %b", tname, c, dut_vec(), model_vec());
      end
      if (stopped_at_gap && !prev_gap) gaps++;
      prev_gap = stopped_at_gap;
      tally();
      model_advance();
    end
    n_checks++;
    if (cnt_pop !== 6 || cnt_bd !== 3 || cnt_tc !== 1 || gaps !== 2) begin
      n_errors++; $display("FAIL %s totals: pops=%0d bd=%0d tc=%0d gaps=%0d want 6 3 1 2", tname, cnt_pop, cnt_bd, cnt_tc, gaps);
    end
  endtask

  task automatic test_count_zero();
    int tc_at = -1;
    tname = "count0";
    clear_tally();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        idle_inputs(); read_dir = 0; block_size = 4; block_count = 0; sys_rvalid = 1;
      end
      start = (c == 0);
      sys_rdata = $urandom;
      #1;
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_errors++; $display("FAIL %s cyc=%0d: outputs %b want %b", tname, c, dut_vec(), model_vec());
      end
      tally();
      model_advance();
    end
    n_checks++;
    if (cnt_push !== 1 || cnt_bd !== 1 || cnt_tc !== 1) begin
      n_errors++; $display("FAIL %s totals: pushes=%0d bd=%0d tc=%0d want 1 1 1", tname, cnt_push, cnt_bd, cnt_tc);
    end
    tname = "size0";
    clear_tally();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        block_size = 0; block_count = 5;
      end
      start = (c == 0);
      #1;
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_errors++; $display("FAIL %s cyc=%0d: outputs %b want %b", tname, c, dut_vec(), model_vec());
      end
      if (transfer_complete) tc_at = c;
      tally();
      model_advance();
    end
    n_checks++;
    if (tc_at !== 2 || cnt_bd !== 0 || cnt_push !== 0 || cnt_tc !== 1) begin
      n_errors++; $display("FAIL %s totals: tc_at=%0d bd=%0d pushes=%0d tc=%0d want 2 0 0 1", tname, tc_at, cnt_bd, cnt_push, cnt_tc);
    end
  endtask

  task automatic test_abort();
    tname = "abort";
    clear_tally();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) begin
        idle_inputs(); read_dir = 1; block_size = 16; block_count = 2;
        sys_wready = 1; rd_fifo_empty = 0;
      end
      start = (c == 0);
      abort = (c == 3);
      rd_fifo_data = $urandom;
      #1;
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_errors++; $display("FAIL %s cyc=%0d: outputs %b want %b", tname, c, dut_vec(), model_vec());
      end
      tally();
      model_advance();
    end
    n_checks++;
    if (cnt_pop !== 2 || cnt_bd !== 0 || cnt_tc !== 0) begin
      n_errors++; $display("FAIL %s totals: pops=%0d bd=%0d tc=%0d want 2 0 0", tname, cnt_pop, cnt_bd, cnt_tc);
    end
    tname = "after_abort";
    clear_tally();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        abort = 0; block_size = 4; block_count = 1;
      end
      start = (c == 0);
      #1;
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_errors++; $display("FAIL %s cyc=%0d: outputs %b want %b", tname, c, dut_vec(), model_vec());
      end
      tally();
      model_advance();
    end
    n_checks++;
    if (cnt_pop !== 1 || cnt_bd !== 1 || cnt_tc !== 1) begin
      n_errors++; $display("FAIL %s totals: pops=%0d bd=%0d tc=%0d want 1 1 1", tname, cnt_pop, cnt_bd, cnt_tc);
    end
  endtask

  task automatic test_reset_mid();
    tname = "reset_mid";
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        idle_inputs(); read_dir = 1; block_size = 16; block_count = 2;
        sys_wready = 1; rd_fifo_empty = 0;
      end
      start = (c == 0);
      #1;
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_errors++; $display("FAIL %s cyc=%0d: outputs %b want %b", tname, c, dut_vec(), model_vec());
      end
      model_advance();
    end
    @(negedge clk);
    #2;
    reset_n = 0;
    #1;
    model_reset();
    n_checks++;
    if (dut_vec() !== 8'h00) begin
      n_errors++; $display("FAIL %s async: got %b want 00000000", tname, dut_vec());
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      start = (c == 1);
      #1;
      n_checks++;
      if (dut_vec() !== 8'h00) begin
        n_errors++; $display("FAIL %s held cyc=%0d: got %b want 00000000", tname, c, dut_vec());
      end
    end
    @(negedge clk);
    start = 0;
    reset_n = 1;
    tname = "post_reset";
    clear_tally();
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 6) begin
        block_size = 8; block_count = 1;
      end
      start = (c == 6);
      #1;
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_errors++; $display("FAIL %s cyc=%0d: outputs %b want %b", tname, c, dut_vec(), model_vec());
      end
      tally();
      model_advance();
    end
    n_checks++;
    if (cnt_pop !== 2 || cnt_bd !== 1 || cnt_tc !== 1) begin
      n_errors++; $display("FAIL %s totals: pops=%0d bd=%0d tc=%0d want 2 1 1", tname, cnt_pop, cnt_bd, cnt_tc);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      bit done = 0;
      tname = $sformatf("random%0d", t);
      for (int c = 0; c < 400 && !done; c++) begin
        @(negedge clk);
        if (c == 0) begin
          read_dir = 1'($urandom_range(0, 1));
          block_size = CW'($urandom_range(0, 24));
          block_count = CW'($urandom_range(0, 3));
          gap_stop = 1'($urandom_range(0, 1));
        end
        start = (c == 0);
        abort = ($urandom_range(0, 79) == 0);
        rd_fifo_empty = ($urandom_range(0, 3) == 0);
        sys_wready = ($urandom_range(0, 3) != 0);
        sys_rvalid = ($urandom_range(0, 3) != 0);
        wr_fifo_full = ($urandom_range(0, 3) == 0);
        continue_req = ($urandom_range(0, 2) == 0);
        rd_fifo_data = $urandom;
        sys_rdata = $urandom;
        #1;
        n_checks++;
        if (dut_vec() !== model_vec()) begin
          n_errors++; $display("FAIL %s cyc=%0d: outputs %b want %b", tname, c, dut_vec(), model_vec());
        end
        n_checks++;
        if (sys_wdata !== rd_fifo_data || wr_fifo_data !== sys_rdata) begin
          n_errors++; $display("FAIL %s passthrough: got %h/%h want %h/%h", tname, sys_wdata, wr_fifo_data, rd_fifo_data, sys_rdata);
        end
        model_advance();
        done = (c > 0) && model_idle() && !m_tc && !m_bd;
      end
      n_checks++;
      if (!done) begin
        n_errors++; $display("FAIL %s timeout: transfer still active after 400 cycles, want idle", tname);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_read_block();
    test_write_full();
    test_gap();
    test_count_zero();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
